// File: rtl/pe_stream_sequencer.sv
// pe_stream_sequencer
//
// Configures one Eyeriss PE and moves a full layer pass through its FIFO ports.
// On an accepted start it latches the layer shape and computes per-channel beat
// counts. It then emits a one-cycle configure pulse and runs three independent
// push engines (ifmap, filter, ipsum) plus an opsum drain engine until every
// count reaches zero.
//
// Optional feature macro: CHECK_EN (in-line comparison of opsums against a
// golden stream; adds exp_valid/exp_data/exp_ready/mismatch_count).
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   start, W,S,F,U,n,p,q    start pulse and layer shape (sampled on accepted start)
//   busy, done, error       status (busy CFG..DONE, done pulse, sticky mismatch)
//   pe_configure, pe_*      one-cycle configure pulse and shape to the PE
//   <ch>_src_valid/ready/data   source streams for ifmap, filter, ipsum
//   push_<ch>, <ch>, <ch>_fifo_full   PE FIFO write side
//   pop_opsum, opsum, opsum_fifo_empty   PE opsum FIFO read side (FWFT)
//   opsum_dst_valid/ready/data           opsum sink stream
module pe_stream_sequencer #(
    parameter int DATA_WIDTH_IFMAP  = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int DATA_WIDTH_PSUM   = 64,
    parameter int PACK_LOG2         = 2,
    parameter int W_WIDTH           = 8,
    parameter int S_WIDTH           = 5,
    parameter int F_WIDTH           = 6,
    parameter int U_WIDTH           = 3,
    parameter int n_WIDTH           = 3,
    parameter int p_WIDTH           = 5,
    parameter int q_WIDTH           = 3,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [W_WIDTH-1:0]           W,
    input  logic [S_WIDTH-1:0]           S,
    input  logic [F_WIDTH-1:0]           F,
    input  logic [U_WIDTH-1:0]           U,
    input  logic [n_WIDTH-1:0]           n,
    input  logic [p_WIDTH-1:0]           p,
    input  logic [q_WIDTH-1:0]           q,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         pe_configure,
    output logic [S_WIDTH-1:0]           pe_S,
    output logic [F_WIDTH-1:0]           pe_F,
    output logic [U_WIDTH-1:0]           pe_U,
    output logic [n_WIDTH-1:0]           pe_n,
    output logic [p_WIDTH-1:0]           pe_p,
    output logic [q_WIDTH-1:0]           pe_q,
    input  logic                         ifmap_src_valid,
    output logic                         ifmap_src_ready,
    input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_src_data,
    input  logic                         filter_src_valid,
    output logic                         filter_src_ready,
    input  logic [DATA_WIDTH_FILTER-1:0] filter_src_data,
    input  logic                         ipsum_src_valid,
    output logic                         ipsum_src_ready,
    input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_src_data,
    output logic                         push_ifmap,
    output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
    output logic                         push_filter,
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    output logic                         push_ipsum,
    output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
    input  logic                         ifmap_fifo_full,
    input  logic                         filter_fifo_full,
    input  logic                         ipsum_fifo_full,
    output logic                         pop_opsum,
    input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
    input  logic                         opsum_fifo_empty,
`ifdef CHECK_EN
    input  logic                         exp_valid,
    input  logic [DATA_WIDTH_PSUM-1:0]   exp_data,
    output logic                         exp_ready,
    output logic [CNT_WIDTH-1:0]         mismatch_count,
`endif
    output logic                         opsum_dst_valid,
    input  logic                         opsum_dst_ready,
    output logic [DATA_WIDTH_PSUM-1:0]   opsum_dst_data
);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DONE} state_t;

    // Product widths; the packed counts carry one extra bit so the round-up
    // addend cannot overflow before the shift.
    localparam int IF_PW = n_WIDTH + W_WIDTH + q_WIDTH;
    localparam int FI_PW = p_WIDTH + q_WIDTH + S_WIDTH + 1;
    localparam int PS_PW = p_WIDTH + n_WIDTH + F_WIDTH + 1;
    localparam int PACK  = 1 << PACK_LOG2;

    state_t                       state_q, state_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         pe_cfg_q, pe_cfg_d;
    logic [S_WIDTH-1:0]           pe_s_q, pe_s_d;
    logic [F_WIDTH-1:0]           pe_f_q, pe_f_d;
    logic [U_WIDTH-1:0]           pe_u_q, pe_u_d;
    logic [n_WIDTH-1:0]           pe_n_q, pe_n_d;
    logic [p_WIDTH-1:0]           pe_p_q, pe_p_d;
    logic [q_WIDTH-1:0]           pe_q_q, pe_q_d;
    logic [CNT_WIDTH-1:0]         rem_if_q, rem_if_d, rem_fi_q, rem_fi_d;
    logic [CNT_WIDTH-1:0]         rem_ps_q, rem_ps_d, rem_op_q, rem_op_d;
    logic                         push_ifmap_q, push_ifmap_d;
    logic [DATA_WIDTH_IFMAP-1:0]  ifmap_q, ifmap_d;
    logic                         push_filter_q, push_filter_d;
    logic [DATA_WIDTH_FILTER-1:0] filter_q, filter_d;
    logic                         push_ipsum_q, push_ipsum_d;
    logic [DATA_WIDTH_PSUM-1:0]   ipsum_q, ipsum_d;
    logic                         pop_q, pop_d;
    logic                         dst_valid_q, dst_valid_d;
    logic [DATA_WIDTH_PSUM-1:0]   dst_data_q, dst_data_d;

    logic [IF_PW-1:0]             prod_if;
    logic [FI_PW-1:0]             sum_fi;
    logic [PS_PW-1:0]             sum_ps;
    logic [CNT_WIDTH-1:0]         cnt_if, cnt_fi, cnt_ps;
    logic                         running, gold_ok, capture;

    assign prod_if = IF_PW'(n) * IF_PW'(W) * IF_PW'(q);
    assign sum_fi  = FI_PW'(p) * FI_PW'(q) * FI_PW'(S) + FI_PW'(PACK - 1);
    assign sum_ps  = PS_PW'(p) * PS_PW'(n) * PS_PW'(F) + PS_PW'(PACK - 1);
    assign cnt_if  = CNT_WIDTH'(prod_if);
    assign cnt_fi  = CNT_WIDTH'(sum_fi >> PACK_LOG2);
    assign cnt_ps  = CNT_WIDTH'(sum_ps >> PACK_LOG2);

    assign running = (state_q == S_RUN);

    // The !push term enforces a one-cycle gap after every push so the PE's
    // registered full flag has time to reflect the beat just written.
    assign ifmap_src_ready  = running && (rem_if_q != '0) && !ifmap_fifo_full  && !push_ifmap_q;
    assign filter_src_ready = running && (rem_fi_q != '0) && !filter_fifo_full && !push_filter_q;
    assign ipsum_src_ready  = running && (rem_ps_q != '0) && !ipsum_fifo_full  && !push_ipsum_q;

`ifdef CHECK_EN
    logic [CNT_WIDTH-1:0] mismatch_q, mismatch_d;
    logic                 error_q, error_d;
    assign gold_ok        = exp_valid;
    assign exp_ready      = capture;
    assign mismatch_count = mismatch_q;
    assign error          = error_q;
`else
    assign gold_ok = 1'b1;
    assign error   = 1'b0;
`endif

    // !pop_q: the FWFT head is still the beat just taken until the pop lands.
    assign capture = running && (rem_op_q != '0) && !opsum_fifo_empty && !pop_q && gold_ok
                     && (!dst_valid_q || opsum_dst_ready);

    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        pe_cfg_d      = 1'b0;
        pe_s_d        = '0;
        pe_f_d        = '0;
        pe_u_d        = '0;
        pe_n_d        = '0;
        pe_p_d        = '0;
        pe_q_d        = '0;
        rem_if_d      = rem_if_q;
        rem_fi_d      = rem_fi_q;
        rem_ps_d      = rem_ps_q;
        rem_op_d      = rem_op_q;
        push_ifmap_d  = 1'b0;
        ifmap_d       = '0;
        push_filter_d = 1'b0;
        filter_d      = '0;
        push_ipsum_d  = 1'b0;
        ipsum_d       = '0;
        pop_d         = 1'b0;
        dst_valid_d   = dst_valid_q;
        dst_data_d    = dst_data_q;
`ifdef CHECK_EN
        mismatch_d    = mismatch_q;
        error_d       = error_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_CFG;
                pe_cfg_d = 1'b1;
                pe_s_d   = S;
                pe_f_d   = F;
                pe_u_d   = U;
                pe_n_d   = n;
                pe_p_d   = p;
                pe_q_d   = q;
                rem_if_d = cnt_if;
                rem_fi_d = cnt_fi;
                rem_ps_d = cnt_ps;
                rem_op_d = cnt_ps;
`ifdef CHECK_EN
                mismatch_d = '0;
                error_d    = 1'b0;
`endif
            end
            S_CFG:  state_d = S_RUN;
            S_RUN:  if ((rem_if_q == '0) && (rem_fi_q == '0) && (rem_ps_q == '0)
                        && (rem_op_q == '0) && !dst_valid_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (ifmap_src_valid && ifmap_src_ready) begin
            push_ifmap_d = 1'b1;
            ifmap_d      = ifmap_src_data;
            rem_if_d     = rem_if_q - CNT_WIDTH'(1);
        end
        if (filter_src_valid && filter_src_ready) begin
            push_filter_d = 1'b1;
            filter_d      = filter_src_data;
            rem_fi_d      = rem_fi_q - CNT_WIDTH'(1);
        end
        if (ipsum_src_valid && ipsum_src_ready) begin
            push_ipsum_d = 1'b1;
            ipsum_d      = ipsum_src_data;
            rem_ps_d     = rem_ps_q - CNT_WIDTH'(1);
        end

        // Drain first so a capture in the same cycle overwrites the slot.
        if (dst_valid_q && opsum_dst_ready) begin
            dst_valid_d = 1'b0;
            dst_data_d  = '0;
        end
        if (capture) begin
            dst_valid_d = 1'b1;
            dst_data_d  = opsum;
            pop_d       = 1'b1;
            rem_op_d    = rem_op_q - CNT_WIDTH'(1);
`ifdef CHECK_EN
            if (opsum != exp_data) begin
                error_d = 1'b1;
                if (mismatch_q != '1) mismatch_d = mismatch_q + CNT_WIDTH'(1);
            end
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pe_cfg_q      <= 1'b0;
            pe_s_q        <= '0;
            pe_f_q        <= '0;
            pe_u_q        <= '0;
            pe_n_q        <= '0;
            pe_p_q        <= '0;
            pe_q_q        <= '0;
            rem_if_q      <= '0;
            rem_fi_q      <= '0;
            rem_ps_q      <= '0;
            rem_op_q      <= '0;
            push_ifmap_q  <= 1'b0;
            ifmap_q       <= '0;
            push_filter_q <= 1'b0;
            filter_q      <= '0;
            push_ipsum_q  <= 1'b0;
            ipsum_q       <= '0;
            pop_q         <= 1'b0;
            dst_valid_q   <= 1'b0;
            dst_data_q    <= '0;
`ifdef CHECK_EN
            mismatch_q    <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pe_cfg_q      <= pe_cfg_d;
            pe_s_q        <= pe_s_d;
            pe_f_q        <= pe_f_d;
            pe_u_q        <= pe_u_d;
            pe_n_q        <= pe_n_d;
            pe_p_q        <= pe_p_d;
            pe_q_q        <= pe_q_d;
            rem_if_q      <= rem_if_d;
            rem_fi_q      <= rem_fi_d;
            rem_ps_q      <= rem_ps_d;
            rem_op_q      <= rem_op_d;
            push_ifmap_q  <= push_ifmap_d;
            ifmap_q       <= ifmap_d;
            push_filter_q <= push_filter_d;
            filter_q      <= filter_d;
            push_ipsum_q  <= push_ipsum_d;
            ipsum_q       <= ipsum_d;
            pop_q         <= pop_d;
            dst_valid_q   <= dst_valid_d;
            dst_data_q    <= dst_data_d;
`ifdef CHECK_EN
            mismatch_q    <= mismatch_d;
            error_q       <= error_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pe_configure    = pe_cfg_q;
    assign pe_S            = pe_s_q;
    assign pe_F            = pe_f_q;
    assign pe_U            = pe_u_q;
    assign pe_n            = pe_n_q;
    assign pe_p            = pe_p_q;
    assign pe_q            = pe_q_q;
    assign push_ifmap      = push_ifmap_q;
    assign ifmap           = ifmap_q;
    assign push_filter     = push_filter_q;
    assign filter          = filter_q;
    assign push_ipsum      = push_ipsum_q;
    assign ipsum           = ipsum_q;
    assign pop_opsum       = pop_q;
    assign opsum_dst_valid = dst_valid_q;
    assign opsum_dst_data  = dst_data_q;

endmodule

// File: doc/pe_stream_sequencer.md
# pe_stream_sequencer

Synthesizable stream sequencer that configures one Eyeriss PE and moves a full layer pass through its four FIFO ports. It sits between the global buffer/NoC streams and the PE wrapper. It issues the PE configure pulse, computes per-channel transfer counts from the layer shape, and drives push/pop pulses with full/empty flow control. Opsums are forwarded to a sink stream, with optional in-line comparison against a golden stream.

## Interface

Parameters:
- DATA_WIDTH_IFMAP, 16, ifmap beat width
- DATA_WIDTH_FILTER, 64, filter beat width (packed weights)
- DATA_WIDTH_PSUM, 64, ipsum/opsum beat width (packed psums)
- PACK_LOG2, 2, log2 of elements per filter/psum beat
- W_WIDTH / S_WIDTH / F_WIDTH / U_WIDTH / n_WIDTH / p_WIDTH / q_WIDTH, 8/5/6/3/3/5/3, shape field widths
- CNT_WIDTH, 16, beat-counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- start  in  1  one-cycle pulse; accepted only in IDLE
- W, S, F, U, n, p, q  in  *_WIDTH  layer shape, sampled on accepted start
- busy  out  1  high from CFG through DONE
- done  out  1  one-cycle pulse in DONE
- error  out  1  sticky mismatch flag (CHECK)
- pe_configure  out  1  one-cycle configure pulse to PE
- pe_S, pe_F, pe_U, pe_n, pe_p, pe_q  out  *_WIDTH  shape to PE, valid only while pe_configure=1, else 0
- ifmap_src_valid/ready  in/out  1; ifmap_src_data  in  DATA_WIDTH_IFMAP
- filter_src_valid/ready  in/out  1; filter_src_data  in  DATA_WIDTH_FILTER
- ipsum_src_valid/ready  in/out  1; ipsum_src_data  in  DATA_WIDTH_PSUM
- push_ifmap/ifmap, push_filter/filter, push_ipsum/ipsum  out  1/width  PE FIFO write side
- ifmap_fifo_full, filter_fifo_full, ipsum_fifo_full  in  1
- pop_opsum  out  1; opsum  in  DATA_WIDTH_PSUM; opsum_fifo_empty  in  1 (first-word fall-through)
- opsum_dst_valid  out  1; opsum_dst_ready  in  1; opsum_dst_data  out  DATA_WIDTH_PSUM

## Operation

- FSM states: IDLE -> CFG -> RUN -> DONE -> IDLE.
- IDLE to CFG on start. Shape registers are latched and counts are registered:
  - N_IF = n*W*q
  - N_FI = ceil(p*q*S / 2^PACK_LOG2)
  - N_PS = N_OP = ceil(p*n*F / 2^PACK_LOG2)
- Ceiling is computed as (prod + 2^PACK_LOG2 - 1) >> PACK_LOG2 in full product width, then truncated to CNT_WIDTH.
- CFG lasts exactly 1 cycle, with pe_configure=1 and the pe_* shape fields driven. The FSM then goes to RUN.
- RUN, per input channel X (independent engines):
  - X_src_ready = RUN & rem_X != 0 & !X_fifo_full & !push_X.
  - A handshake registers push_X=1 and X=src_data for exactly one cycle, then decrements rem_X.
  - push_X is 0 in the cycle after any push, giving a 2-cycle cadence that hides the FIFO full-flag latency. Data outputs are 0 when not pushing.
- RUN, opsum capture is allowed when all of these hold: rem_OP != 0, !opsum_fifo_empty, !pop_opsum, and the output register is empty or draining this cycle.
  - On capture, opsum_dst_data <= opsum, opsum_dst_valid <= 1, pop_opsum <= 1 for one cycle, and rem_OP is decremented.
  - opsum_dst_valid holds until opsum_dst_ready.
- RUN to DONE when all four rem counts are 0 and opsum_dst_valid=0. DONE lasts 1 cycle with done=1, then the FSM returns to IDLE.
- Boundary conditions:
  - A zero count (e.g. n=0) marks that channel complete immediately.
  - An all-zero shape gives the sequence IDLE, CFG, RUN(1), DONE.
  - start while busy is ignored.
  - Shape input changes after start have no effect.
  - Assertion of reset mid-pass abandons the pass. Outputs return to reset values immediately; no pulses are emitted.

## Timing

- Reset values: every output is 0, including busy, done, error, pe_configure, all push_*, pop_opsum, opsum_dst_valid and data; FSM is in IDLE.
- Start accepted at edge t gives:
  - pe_configure=1 during cycle t+1
  - RUN from t+2
  - first possible push visible in cycle t+3
- Source handshake at edge c gives push_X=1 in cycle c+1.
- Peak rate is 1 beat per 2 cycles per channel.
- Capture at edge c gives pop_opsum=1 and dst_valid=1 in cycle c+1.
- done follows the last drain by 2 edges.

## Configuration

- CHECK_EN defined:
  - Adds ports exp_valid in 1, exp_data in DATA_WIDTH_PSUM, exp_ready out 1, and mismatch_count out CNT_WIDTH.
  - Capture additionally requires exp_valid. exp_ready pulses on capture.
  - Each captured opsum != exp_data increments mismatch_count (saturating) and sets error (sticky until reset or next accepted start).
  - Both are cleared on accepted start.
- CHECK_EN undefined: these ports are absent, capture ignores the golden stream, and error is tied to 0.

## Test plan

- AlexNet CONV1 pass (W=227, S=11, F=55, U=4, n=1, p=16, q=1), all sources always valid, sink always ready -> exactly 227 ifmap, 44 filter and 220 ipsum pushes, and 220 pops. pe_configure is one cycle with pe_S=11. done occurs once, then busy=0.
- Hold ifmap_fifo_full=1 for 20 cycles mid-pass -> no push_ifmap and ifmap_src_ready=0 throughout. Other channels continue, and the total ifmap count is still 227.
- opsum_dst_ready=0 for 10 cycles with a non-empty FIFO -> one beat held stable on opsum_dst_data, no further pop_opsum, and no beat lost or duplicated after release.
- Shape p=3, n=1, F=5 -> N_PS=N_OP=4 (ceil of 15/4). Shape n=0 -> ifmap and psum channels idle, and only the filter beats run.
- Reset asserted in RUN with 100 ifmap beats pushed -> all outputs 0 asynchronously. A new start with the CONV1 shape then completes with full counts.
- CHECK_EN: golden stream with index 7 corrupted -> mismatch_count=1 and error=1 at done. The next start clears both.
